coriolis_ker1_subker1_join2: RTL

Stream join node at the consuming end of the latency-matching buffers. Accepts two independent valid/ready streams, holds each in a small FIFO, and emits one combined output beat only when both inputs have data. Absorbs residual skew between parallel datapath branches before they feed the next kernel operator.

---
 rtl/coriolis_ker1_subker1_join2_pkg.sv | 22 ++
 rtl/coriolis_ker1_subker1_join_fifo.sv | 61 ++++++
 rtl/coriolis_ker1_subker1_join2.sv | 75 +++++++
 3 files changed

// File: rtl/coriolis_ker1_subker1_join2_pkg.sv
// Shared widths and sizing helper for the two-lane stream join.
// Defaults describe the 32-bit, 4-deep configuration.
package coriolis_ker1_subker1_join2_pkg;

    localparam int STREAMW_D = 32;
    localparam int DEPTH_D   = 4;

    // Occupancy needs one extra bit so a full FIFO reads as DEPTH.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LVLW_D = lvl_width(DEPTH_D);

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/coriolis_ker1_subker1_join_fifo.sv
// Circular FIFO lane with registered pointers/count and a
// combinational head read; memory contents survive reset.
module coriolis_ker1_subker1_join_fifo
    import coriolis_ker1_subker1_join2_pkg::*;
#(
    parameter int W     = STREAMW_D,
    parameter int DEPTH = DEPTH_D,
    parameter int LVLW  = LVLW_D
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic [W-1:0]    i_din,
    input  logic            i_pop,
    output logic            o_full,
    output logic            o_empty,
    output logic [LVLW-1:0] o_level,
    output logic [W-1:0]    o_head
);

    localparam int PW = LVLW - 1;

    logic [W-1:0]    r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [LVLW-1:0] r_cnt;
    fifo_op_e        w_op;

    assign w_op    = fifo_op_e'({i_pop, i_push});
    assign o_full  = (r_cnt == LVLW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_level = r_cnt;
    assign o_head  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case (w_op)
                OP_PUSH: r_cnt <= r_cnt + 1'b1;
                OP_POP:  r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/coriolis_ker1_subker1_join2.sv
// Two-lane stream join: each lane buffered in its own FIFO, one
// joined beat emitted when both heads are present.
module coriolis_ker1_subker1_join2
    import coriolis_ker1_subker1_join2_pkg::*;
#(
    parameter int STREAMW = STREAMW_D,
    parameter int DEPTH   = DEPTH_D,
    parameter int LVLW    = LVLW_D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ivalid_in1,
    input  logic [STREAMW-1:0] in1,
    output logic               iready_in1,
    input  logic               ivalid_in2,
    input  logic [STREAMW-1:0] in2,
    output logic               iready_in2,
    output logic               ovalid,
    input  logic               oready,
    output logic [STREAMW-1:0] out1,
    output logic [STREAMW-1:0] out2,
    output logic [LVLW-1:0]    lvl_in1,
    output logic [LVLW-1:0]    lvl_in2
);

    logic w_full1;
    logic w_full2;
    logic w_empty1;
    logic w_empty2;
    logic w_push1;
    logic w_push2;
    logic w_pop;

    // Ready looks only at registered fullness, so a same-cycle pop
    // never frees a slot for a push.
    assign iready_in1 = ~w_full1 & ~rst;
    assign iready_in2 = ~w_full2 & ~rst;
    assign w_push1    = ivalid_in1 & iready_in1;
    assign w_push2    = ivalid_in2 & iready_in2;
    assign ovalid     = ~w_empty1 & ~w_empty2;
    assign w_pop      = ovalid & oready;

    coriolis_ker1_subker1_join_fifo #(
        .W     (STREAMW),
        .DEPTH (DEPTH),
        .LVLW  (LVLW)
    ) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push1),
        .i_din   (in1),
        .i_pop   (w_pop),
        .o_full  (w_full1),
        .o_empty (w_empty1),
        .o_level (lvl_in1),
        .o_head  (out1)
    );

    coriolis_ker1_subker1_join_fifo #(
        .W     (STREAMW),
        .DEPTH (DEPTH),
        .LVLW  (LVLW)
    ) u_fifo2 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push2),
        .i_din   (in2),
        .i_pop   (w_pop),
        .o_full  (w_full2),
        .o_empty (w_empty2),
        .o_level (lvl_in2),
        .o_head  (out2)
    );

endmodule
